// File: rtl/strobe_conditioner.sv
// strobe_conditioner: resynchronises asynchronous detector strobes into the
// clk domain and detects the selected edge on each line. Every accepted edge
// produces a one-cycle pulse on strobe_out. Each channel then enters a
// programmable dead time, and edges that arrive during it are counted.
module strobe_conditioner #(
    parameter int N_CHANNELS    = 100,
    parameter int SYNC_STAGES   = 2,
    parameter int HOLDOFF_WIDTH = 8,
    parameter int COUNT_WIDTH   = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_CHANNELS-1:0]    strobe_in,
    input  logic                     enable,
    input  logic                     edge_select,
    input  logic [HOLDOFF_WIDTH-1:0] holdoff,
    input  logic                     clear_counts,
    output logic [N_CHANNELS-1:0]    strobe_out,
    output logic                     any_strobe,
    output logic [COUNT_WIDTH-1:0]   dropped_count
);

    // The warm-up counter must outlast the synchroniser plus the prev flop.
    // This stops a line that is already high at reset exit from looking like an edge.
    localparam int WARM_MAX = SYNC_STAGES + 1;
    localparam int WARM_W   = ($clog2(WARM_MAX + 1) < 2) ? 2 : $clog2(WARM_MAX + 1);
    localparam logic [WARM_W-1:0] WARM_DONE = WARM_W'(WARM_MAX);

    // The sum is wide enough to hold the current count plus a full popcount.
    // That makes saturation a plain magnitude compare.
    localparam int POP_W = $clog2(N_CHANNELS + 1);
    localparam int SUM_W = ((COUNT_WIDTH > POP_W) ? COUNT_WIDTH : POP_W) + 1;
    localparam logic [SUM_W-1:0] COUNT_MAX = SUM_W'({COUNT_WIDTH{1'b1}});

    logic [SYNC_STAGES-1:0][N_CHANNELS-1:0]    sync_q, sync_d;
    logic [N_CHANNELS-1:0]                     prev_q, prev_d;
    logic [N_CHANNELS-1:0][HOLDOFF_WIDTH-1:0]  ho_q, ho_d;
    logic [WARM_W-1:0]                         warm_q, warm_d;
    logic [N_CHANNELS-1:0]                     strobe_out_q, strobe_out_d;
    logic                                      any_strobe_q, any_strobe_d;
    logic [COUNT_WIDTH-1:0]                    dropped_count_q, dropped_count_d;

    logic                  armed;
    logic [N_CHANNELS-1:0] sync_now;
    logic [N_CHANNELS-1:0] edge_det;
    logic [N_CHANNELS-1:0] live;
    logic [N_CHANNELS-1:0] busy;
    logic [N_CHANNELS-1:0] accept;
    logic [N_CHANNELS-1:0] reject;
    logic [SUM_W-1:0]      pop;
    logic [SUM_W-1:0]      sum;

    // Shift every raw strobe through the synchroniser and remember the last settled level.
    // The chain keeps tracking while disabled, so re-enabling never sees stale state.
    always_comb begin
        sync_d    = '0;
        sync_d[0] = strobe_in;
        for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end
        sync_now = sync_q[SYNC_STAGES-1];
        prev_d   = sync_now;
    end

    // Count up after reset until armed, then hold. Detections before that point are discarded.
    always_comb begin
        armed  = (warm_q == WARM_DONE);
        warm_d = armed ? warm_q : (warm_q + WARM_W'(1));
    end

    // Edge detection depends only on the sync/prev pair.
    // Flipping edge_select while the line is stable therefore produces no edge.
    always_comb begin
        edge_det = edge_select ? (~sync_now & prev_q) : (sync_now & ~prev_q);
        live     = edge_det & {N_CHANNELS{armed & enable}};
        busy     = '0;
        for (int i = 0; i < N_CHANNELS; i++) begin
            busy[i] = (ho_q[i] != '0);
        end
        accept = live & ~busy;
        reject = live & busy;
    end

    // Per-channel dead time.
    // holdoff is sampled only when an edge is accepted; the counter then runs down to zero.
    // Disabling the block clears every counter at once.
    always_comb begin
        ho_d = '0;
        for (int i = 0; i < N_CHANNELS; i++) begin
            if (!enable) begin
                ho_d[i] = '0;
            end else if (accept[i]) begin
                ho_d[i] = holdoff;
            end else if (busy[i]) begin
                ho_d[i] = ho_q[i] - HOLDOFF_WIDTH'(1);
            end else begin
                ho_d[i] = '0;
            end
        end
    end

    // Add up this cycle's rejected edges and saturate the diagnostic counter.
    // A clear request beats any drops that arrive in the same cycle.
    always_comb begin
        pop = '0;
        for (int i = 0; i < N_CHANNELS; i++) begin
            pop = pop + SUM_W'(reject[i]);
        end
        sum = SUM_W'(dropped_count_q) + pop;
        if (clear_counts) begin
            dropped_count_d = '0;
        end else if (sum > COUNT_MAX) begin
            dropped_count_d = '1;
        end else begin
            dropped_count_d = sum[COUNT_WIDTH-1:0];
        end
    end

    // Register the pulses so the tagger sees clean, glitch-free strobes.
    always_comb begin
        strobe_out_d = accept;
        any_strobe_d = |accept;
    end

    // All state is cleared asynchronously, so a pulse in flight is dropped on reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q          <= '0;
            prev_q          <= '0;
            ho_q            <= '0;
            warm_q          <= '0;
            strobe_out_q    <= '0;
            any_strobe_q    <= 1'b0;
            dropped_count_q <= '0;
        end else begin
            sync_q          <= sync_d;
            prev_q          <= prev_d;
            ho_q            <= ho_d;
            warm_q          <= warm_d;
            strobe_out_q    <= strobe_out_d;
            any_strobe_q    <= any_strobe_d;
            dropped_count_q <= dropped_count_d;
        end
    end

    assign strobe_out    = strobe_out_q;
    assign any_strobe    = any_strobe_q;
    assign dropped_count = dropped_count_q;

endmodule

// File: tb/tb_strobe_conditioner.sv
// Testbench for strobe_conditioner with four channels.
// Each vector is driven on the falling edge and its expected result is queued.
// The result is popped and compared just after the following rising edge.
module tb_strobe_conditioner;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  strobe_in;
    logic        enable;
    logic        edge_select;
    logic [7:0]  holdoff;
    logic        clear_counts;
    logic [3:0]  strobe_out;
    logic        any_strobe;
    logic [15:0] dropped_count;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0]  strb;
        logic        en;
        logic        esel;
        logic [7:0]  ho;
        logic        clr;
        logic [3:0]  exp_out;
        logic        exp_any;
        logic [15:0] exp_cnt;
    } vec_t;

    typedef struct {
        logic [3:0]  out;
        logic        any;
        logic [15:0] cnt;
        string       tag;
    } exp_t;

    vec_t vecs[$];
    exp_t sbq[$];

    strobe_conditioner #(
        .N_CHANNELS   (4),
        .SYNC_STAGES  (2),
        .HOLDOFF_WIDTH(8),
        .COUNT_WIDTH  (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .strobe_in    (strobe_in),
        .enable       (enable),
        .edge_select  (edge_select),
        .holdoff      (holdoff),
        .clear_counts (clear_counts),
        .strobe_out   (strobe_out),
        .any_strobe   (any_strobe),
        .dropped_count(dropped_count)
    );

    // Free-running 10-time-unit clock.
    always #5 clk = ~clk;

    task automatic addVec(input logic [3:0] strb, input logic en, input logic esel,
                          input logic [7:0] ho, input logic clr,
                          input logic [3:0] eo, input logic ea, input logic [15:0] ec);
        vec_t v;
        v.strb = strb; v.en = en; v.esel = esel; v.ho = ho; v.clr = clr;
        v.exp_out = eo; v.exp_any = ea; v.exp_cnt = ec;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic [3:0] strb, input logic en, input logic esel,
                         input logic [7:0] ho, input logic clr);
        @(negedge clk);
        strobe_in    = strb;
        enable       = en;
        edge_select  = esel;
        holdoff      = ho;
        clear_counts = clr;
    endtask

    task automatic pushExpect(input logic [3:0] eo, input logic ea, input logic [15:0] ec,
                              input string tag);
        exp_t e;
        e.out = eo; e.any = ea; e.cnt = ec; e.tag = tag;
        sbq.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t e;
        total++;
        if (sbq.size() == 0) begin
            bad++;
            $display("[TB] FAIL scoreboard_empty: got out=%b any=%b cnt=%h, nothing expected",
                     strobe_out, any_strobe, dropped_count);
        end else begin
            e = sbq.pop_front();
            if (strobe_out !== e.out || any_strobe !== e.any || dropped_count !== e.cnt) begin
                bad++;
                $display("[TB] FAIL %s: got out=%b any=%b cnt=%h, expected out=%b any=%b cnt=%h",
                         e.tag, strobe_out, any_strobe, dropped_count, e.out, e.any, e.cnt);
            end
        end
    endtask

    task automatic applyStimulus(input vec_t v, input string tag);
        drive(v.strb, v.en, v.esel, v.ho, v.clr);
        pushExpect(v.exp_out, v.exp_any, v.exp_cnt, tag);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic expectNow(input logic [3:0] eo, input logic ea, input logic [15:0] ec,
                             input string tag);
        pushExpect(eo, ea, ec, tag);
        checkOutput();
    endtask

    // Rising-edge burst with holdoff 255.
    // The first edge on each masked channel is accepted; the next r edges are rejected.
    // The count therefore grows by popcount(mask)*r.
    task automatic burst(input logic [3:0] mask, input int r);
        for (int k = 0; k <= r; k++) begin
            drive(mask, 1'b1, 1'b0, 8'd255, 1'b0);
            drive(4'b0000, 1'b1, 1'b0, 8'd255, 1'b0);
        end
        for (int k = 0; k < 3; k++) begin
            drive(4'b0000, 1'b1, 1'b0, 8'd255, 1'b0);
        end
        drive(4'b0000, 1'b0, 1'b0, 8'd255, 1'b0);
    endtask

    initial begin
        vec_t idle;

        // Settle all lines low; falling edges are ignored in rising mode.
        for (int k = 0; k < 4; k++) addVec(4'b0000, 1, 0, 8'd0, 0, 4'b0000, 0, 16'd0);
        // Channel 0 rises with holdoff 0; one pulse two edges later.
        addVec(4'b0001, 1, 0, 8'd0, 0, 4'b0000, 0, 16'd0);
        addVec(4'b0001, 1, 0, 8'd0, 0, 4'b0000, 0, 16'd0);
        addVec(4'b0001, 1, 0, 8'd0, 0, 4'b0001, 1, 16'd0);
        addVec(4'b0001, 1, 0, 8'd0, 0, 4'b0000, 0, 16'd0);
        for (int k = 0; k < 3; k++) addVec(4'b0000, 1, 0, 8'd0, 0, 4'b0000, 0, 16'd0);
        // Holdoff 5 on channel 1: detections at t, t+2 (dropped) and t+6.
        addVec(4'b0010, 1, 0, 8'd5, 0, 4'b0000, 0, 16'd0);
        addVec(4'b0000, 1, 0, 8'd5, 0, 4'b0000, 0, 16'd0);
        addVec(4'b0010, 1, 0, 8'd5, 0, 4'b0010, 1, 16'd0);
        addVec(4'b0010, 1, 0, 8'd5, 0, 4'b0000, 0, 16'd0);
        addVec(4'b0010, 1, 0, 8'd5, 0, 4'b0000, 0, 16'd1);
        addVec(4'b0000, 1, 0, 8'd5, 0, 4'b0000, 0, 16'd1);
        addVec(4'b0010, 1, 0, 8'd5, 0, 4'b0000, 0, 16'd1);
        addVec(4'b0010, 1, 0, 8'd5, 0, 4'b0000, 0, 16'd1);
        addVec(4'b0010, 1, 0, 8'd5, 0, 4'b0010, 1, 16'd1);
        addVec(4'b0010, 1, 0, 8'd5, 0, 4'b0000, 0, 16'd1);
        for (int k = 0; k < 4; k++) addVec(4'b0000, 1, 0, 8'd5, 0, 4'b0000, 0, 16'd1);
        // All four accepted together, then all four rejected in one cycle.
        addVec(4'b1111, 1, 0, 8'd5, 0, 4'b0000, 0, 16'd1);
        addVec(4'b1111, 1, 0, 8'd5, 0, 4'b0000, 0, 16'd1);
        addVec(4'b0000, 1, 0, 8'd5, 0, 4'b1111, 1, 16'd1);
        addVec(4'b1111, 1, 0, 8'd5, 0, 4'b0000, 0, 16'd1);
        addVec(4'b1111, 1, 0, 8'd5, 0, 4'b0000, 0, 16'd1);
        addVec(4'b1111, 1, 0, 8'd5, 0, 4'b0000, 0, 16'd5);
        // Two drops in the same cycle as clear_counts.
        addVec(4'b0000, 1, 0, 8'd5, 0, 4'b0000, 0, 16'd5);
        addVec(4'b0000, 1, 0, 8'd5, 0, 4'b0000, 0, 16'd5);
        addVec(4'b0011, 1, 0, 8'd5, 0, 4'b0000, 0, 16'd5);
        addVec(4'b0000, 1, 0, 8'd5, 0, 4'b0000, 0, 16'd5);
        addVec(4'b0011, 1, 0, 8'd5, 0, 4'b0011, 1, 16'd5);
        addVec(4'b0000, 1, 0, 8'd5, 0, 4'b0000, 0, 16'd5);
        addVec(4'b0011, 1, 0, 8'd5, 1, 4'b0000, 0, 16'd0);
        addVec(4'b0000, 1, 0, 8'd5, 0, 4'b0000, 0, 16'd0);
        // Disabled while channel 2 toggles three times and channels 0/1 are still in holdoff.
        addVec(4'b0000, 0, 0, 8'd0, 0, 4'b0000, 0, 16'd0);
        addVec(4'b0100, 0, 0, 8'd0, 0, 4'b0000, 0, 16'd0);
        addVec(4'b0000, 0, 0, 8'd0, 0, 4'b0000, 0, 16'd0);
        addVec(4'b0100, 0, 0, 8'd0, 0, 4'b0000, 0, 16'd0);
        addVec(4'b0000, 0, 0, 8'd0, 0, 4'b0000, 0, 16'd0);
        addVec(4'b0100, 0, 0, 8'd0, 0, 4'b0000, 0, 16'd0);
        addVec(4'b0100, 0, 0, 8'd0, 0, 4'b0000, 0, 16'd0);
        // Re-enable in falling mode with the line high, then let it fall.
        for (int k = 0; k < 3; k++) addVec(4'b0100, 1, 1, 8'd0, 0, 4'b0000, 0, 16'd0);
        addVec(4'b0000, 1, 1, 8'd0, 0, 4'b0000, 0, 16'd0);
        addVec(4'b0000, 1, 1, 8'd0, 0, 4'b0000, 0, 16'd0);
        addVec(4'b0000, 1, 1, 8'd0, 0, 4'b0100, 1, 16'd0);
        addVec(4'b0000, 1, 1, 8'd0, 0, 4'b0000, 0, 16'd0);
        // Switching back to rising mode on quiet lines creates no edge.
        addVec(4'b0000, 1, 0, 8'd0, 0, 4'b0000, 0, 16'd0);
        addVec(4'b0000, 1, 0, 8'd0, 0, 4'b0000, 0, 16'd0);

        // Reset with every line already high: no pulse during warm-up.
        reset        = 1'b0;
        strobe_in    = 4'b1111;
        enable       = 1'b1;
        edge_select  = 1'b0;
        holdoff      = 8'd0;
        clear_counts = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        expectNow(4'b0000, 1'b0, 16'd0, "in_reset");
        reset = 1'b1;
        idle.strb = 4'b1111; idle.en = 1'b1; idle.esel = 1'b0; idle.ho = 8'd0; idle.clr = 1'b0;
        idle.exp_out = 4'b0000; idle.exp_any = 1'b0; idle.exp_cnt = 16'd0;
        for (int k = 0; k < 10; k++) begin
            applyStimulus(idle, $sformatf("warmup%0d", k));
        end

        $display("[TB] applying %0d table vectors", vecs.size());
        for (int k = 0; k < vecs.size(); k++) begin
            applyStimulus(vecs[k], $sformatf("vec%0d", k));
        end

        // Bring the counter up to 0xFFFE through real drops.
        idle.strb = 4'b0000; idle.ho = 8'd255;
        burst(4'b1111, 126);
        idle.exp_cnt = 16'd504;
        applyStimulus(idle, "pump_first");
        for (int k = 0; k < 129; k++) burst(4'b1111, 126);
        burst(4'b1111, 3);
        burst(4'b0011, 1);
        idle.exp_cnt = 16'hFFFE;
        applyStimulus(idle, "preload");

        // Four drops at once from 0xFFFE must saturate, not wrap.
        burst(4'b1111, 1);
        idle.exp_cnt = 16'hFFFF;
        applyStimulus(idle, "saturate");
        burst(4'b0011, 1);
        applyStimulus(idle, "stay_saturated");

        // Reset asserted mid-cycle clears the count immediately.
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        expectNow(4'b0000, 1'b0, 16'd0, "async_reset");
        @(posedge clk);
        #1;
        reset = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
